// File: rtl/pulse_gap_detector.sv
// -----------------------------------------------------------------------------
// pulse_gap_detector
//
// Receive-side checker for a serial pulse/gap stream (for example the
// shift_out of a circular shift register pattern generator). The line is
// sampled every clock and the run of 0 samples in front of each rising
// edge is measured. Once that gap repeats LOCK_COUNT times after the
// reference gap, the detector reports lock. Gap changes and over-long
// silences are flagged.
//
// Optional feature macro: PULSEGAP_STICKY_ERR_EN
//   defined   : err_sticky_o latches any mismatch/timeout until reset
//   undefined : err_sticky_o is tied to 0 and no register is built
//
// Parameters
//   GAP_W       width of the gap counter and gap_len_o (saturates at 2**GAP_W-1)
//   LOCK_COUNT  consecutive matches after the reference gap needed for lock (1..15)
//
// Ports
//   clock_i       system clock, rising edge
//   reset_i       synchronous active-high reset
//   serial_in_i   serial pulse stream
//   pulse_seen_o  1-cycle strobe: rising edge of serial_in_i detected
//   gap_len_o     last measured gap (0 samples before the latest edge)
//   gap_valid_o   1-cycle strobe: gap_len_o updated
//   locked_o      level: gap stable for LOCK_COUNT consecutive matches
//   mismatch_o    1-cycle strobe: gap differed from reference in TRACK/LOCKED
//   timeout_o     1-cycle strobe: gap counter saturated with no edge
//   err_sticky_o  sticky error flag (see macro above)
//
// All outputs are registered; strobes appear one cycle after the sample
// that caused them.
// -----------------------------------------------------------------------------
module pulse_gap_detector #(
    parameter int unsigned GAP_W      = 8,
    parameter int unsigned LOCK_COUNT = 3
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             serial_in_i,
    output logic             pulse_seen_o,
    output logic [GAP_W-1:0] gap_len_o,
    output logic             gap_valid_o,
    output logic             locked_o,
    output logic             mismatch_o,
    output logic             timeout_o,
    output logic             err_sticky_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_TRACK   = 2'd2,
        ST_LOCKED  = 2'd3
    } state_e;

    localparam logic [GAP_W-1:0] GAP_MAX  = {GAP_W{1'b1}};
    localparam logic [GAP_W-1:0] GAP_ONE  = {{(GAP_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]       LOCK_TGT = 4'(LOCK_COUNT);

    state_e           state_q, state_d;
    logic             s_q;
    logic [GAP_W-1:0] zero_cnt_q, zero_cnt_d;
    logic [GAP_W-1:0] ref_gap_q, ref_gap_d;
    logic [3:0]       match_cnt_q, match_cnt_d;
    logic [GAP_W-1:0] gap_len_q, gap_len_d;
    logic             pulse_seen_q, pulse_seen_d;
    logic             gap_valid_q, gap_valid_d;
    logic             locked_q, locked_d;
    logic             mismatch_q, mismatch_d;
    logic             timeout_q, timeout_d;

    logic             edge_s;
    logic             sat_s;

    // A 1 after a 0 is an edge; s_q clears on reset so a 1 right after reset counts.
    assign edge_s = serial_in_i & ~s_q;
    assign sat_s  = (zero_cnt_q == GAP_MAX);

    // Gap counter: cleared on edge, counts 0 samples, holds on 1 samples and at saturation.
    always_comb begin
        zero_cnt_d = zero_cnt_q;
        if (edge_s) begin
            zero_cnt_d = '0;
        end else if (!serial_in_i && !sat_s) begin
            zero_cnt_d = zero_cnt_q + GAP_ONE;
        end else begin
            zero_cnt_d = zero_cnt_q;
        end
    end

    // FSM next state and registered-output next values.
    always_comb begin
        state_d      = state_q;
        ref_gap_d    = ref_gap_q;
        match_cnt_d  = match_cnt_q;
        gap_len_d    = gap_len_q;
        pulse_seen_d = edge_s;
        gap_valid_d  = 1'b0;
        mismatch_d   = 1'b0;
        timeout_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // IDLE has no reference gap yet and never times out.
                if (edge_s) begin
                    state_d = ST_MEASURE;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_MEASURE: begin
                // The edge takes priority over saturation: a saturated gap is still a gap.
                if (edge_s) begin
                    ref_gap_d   = zero_cnt_q;
                    gap_len_d   = zero_cnt_q;
                    gap_valid_d = 1'b1;
                    match_cnt_d = 4'd0;
                    state_d     = ST_TRACK;
                end else if (sat_s) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_MEASURE;
                end
            end

            ST_TRACK: begin
                if (edge_s) begin
                    gap_len_d   = zero_cnt_q;
                    gap_valid_d = 1'b1;
                    if (zero_cnt_q == ref_gap_q) begin
                        match_cnt_d = match_cnt_q + 4'd1;
                        if ((match_cnt_q + 4'd1) >= LOCK_TGT) begin
                            state_d = ST_LOCKED;
                        end else begin
                            state_d = ST_TRACK;
                        end
                    end else begin
                        // New gap becomes the reference; counting restarts from it.
                        mismatch_d  = 1'b1;
                        ref_gap_d   = zero_cnt_q;
                        match_cnt_d = 4'd0;
                        state_d     = ST_TRACK;
                    end
                end else if (sat_s) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_TRACK;
                end
            end

            ST_LOCKED: begin
                if (edge_s) begin
                    gap_len_d   = zero_cnt_q;
                    gap_valid_d = 1'b1;
                    if (zero_cnt_q == ref_gap_q) begin
                        state_d = ST_LOCKED;
                    end else begin
                        mismatch_d  = 1'b1;
                        ref_gap_d   = zero_cnt_q;
                        match_cnt_d = 4'd0;
                        state_d     = ST_TRACK;
                    end
                end else if (sat_s) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_LOCKED;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Lock is a pure function of the state being entered.
        locked_d = (state_d == ST_LOCKED);
    end

    // State, sampling and output registers with synchronous reset.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            s_q          <= 1'b0;
            zero_cnt_q   <= '0;
            ref_gap_q    <= '0;
            match_cnt_q  <= 4'd0;
            gap_len_q    <= '0;
            pulse_seen_q <= 1'b0;
            gap_valid_q  <= 1'b0;
            locked_q     <= 1'b0;
            mismatch_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_q          <= serial_in_i;
            zero_cnt_q   <= zero_cnt_d;
            ref_gap_q    <= ref_gap_d;
            match_cnt_q  <= match_cnt_d;
            gap_len_q    <= gap_len_d;
            pulse_seen_q <= pulse_seen_d;
            gap_valid_q  <= gap_valid_d;
            locked_q     <= locked_d;
            mismatch_q   <= mismatch_d;
            timeout_q    <= timeout_d;
        end
    end

    assign pulse_seen_o = pulse_seen_q;
    assign gap_len_o    = gap_len_q;
    assign gap_valid_o  = gap_valid_q;
    assign locked_o     = locked_q;
    assign mismatch_o   = mismatch_q;
    assign timeout_o    = timeout_q;

`ifdef PULSEGAP_STICKY_ERR_EN
    logic err_q;

    // Sticky error: rises together with the first mismatch/timeout strobe, cleared only by reset.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | mismatch_d | timeout_d;
        end
    end

    assign err_sticky_o = err_q;
`else
    assign err_sticky_o = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_gap_detector.sv
module tb_pulse_gap_detector;

    logic       clk;
    logic       reset;
    logic       serial_in;
    logic       pulse_seen;
    logic [7:0] gap_len;
    logic       gap_valid;
    logic       locked;
    logic       mismatch;
    logic       timeout;
    logic       err_sticky;

`ifdef PULSEGAP_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    pulse_gap_detector #(
        .GAP_W      (8),
        .LOCK_COUNT (3)
    ) dut (
        .clock_i      (clk),
        .reset_i      (reset),
        .serial_in_i  (serial_in),
        .pulse_seen_o (pulse_seen),
        .gap_len_o    (gap_len),
        .gap_valid_o  (gap_valid),
        .locked_o     (locked),
        .mismatch_o   (mismatch),
        .timeout_o    (timeout),
        .err_sticky_o (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected vector layout: {pulse_seen, gap_len[7:0], gap_valid, locked, mismatch, timeout, err_sticky}
    logic [13:0] exp_q[$];
    logic [7:0]  cur_gap;
    logic        cur_lock;
    logic        cur_err;
    int          vectors;
    int          miscompares;
    string       tag;

    // Pop the oldest expectation and compare it with what the DUT shows now.
    task automatic check_out();
        logic [13:0] e;
        logic [13:0] o;
        e = exp_q.pop_front();
        o = {pulse_seen, gap_len, gap_valid, locked, mismatch, timeout, err_sticky};
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s vec=%0d obs ps=%b gap=%0d gv=%b lk=%b mm=%b to=%b es=%b exp ps=%b gap=%0d gv=%b lk=%b mm=%b to=%b es=%b",
                   tag, vectors, o[13], o[12:5], o[4], o[3], o[2], o[1], o[0],
                   e[13], e[12:5], e[4], e[3], e[2], e[1], e[0]);
        end
    endtask

    // Drive one sample (called at negedge), record what must appear after the next posedge.
    task automatic tick(input logic b, input logic ps, input logic gv, input logic [7:0] gl,
                        input logic lk, input logic mm, input logic to);
        serial_in = b;
        if (gv) cur_gap = gl;
        cur_lock = lk;
        if (STICKY && (mm || to)) cur_err = 1'b1;
        exp_q.push_back({ps, cur_gap, gv, cur_lock, mm, to, cur_err});
        @(posedge clk);
        #1;
        check_out();
        @(negedge clk);
    endtask

    // Non-edge sample: no strobes, levels held.
    task automatic quiet(input logic b);
        tick(b, 1'b0, 1'b0, 8'd0, cur_lock, 1'b0, 1'b0);
    endtask

    task automatic quiet_n(input logic b, input int n);
        for (int i = 0; i < n; i++) quiet(b);
    endtask

    // hi ones then lo zeros; the first 1 is an edge carrying the given expectations.
    task automatic burst(input int hi, input int lo, input logic gv, input logic [7:0] gl,
                         input logic lk, input logic mm);
        tick(1'b1, 1'b1, gv, gl, lk, mm, 1'b0);
        quiet_n(1'b1, hi - 1);
        quiet_n(1'b0, lo);
    endtask

    // One reset cycle with the given serial level; everything must read 0 afterwards.
    task automatic do_reset(input logic b);
        reset     = 1'b1;
        serial_in = b;
        cur_gap   = 8'd0;
        cur_lock  = 1'b0;
        cur_err   = 1'b0;
        exp_q.push_back(14'd0);
        @(posedge clk);
        #1;
        check_out();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        serial_in   = 1'b0;
        cur_gap     = 8'd0;
        cur_lock    = 1'b0;
        cur_err     = 1'b0;
        @(negedge clk);

        tag = "reset";
        do_reset(1'b0);
        quiet(1'b0);

        // Period-8 pattern: gap 7, lock with the 5th edge.
        tag = "gap7_lock";
        burst(1, 7, 1'b0, 8'd0, 1'b0, 1'b0);
        burst(1, 7, 1'b1, 8'd7, 1'b0, 1'b0);
        burst(1, 7, 1'b1, 8'd7, 1'b0, 1'b0);
        burst(1, 7, 1'b1, 8'd7, 1'b0, 1'b0);
        burst(1, 7, 1'b1, 8'd7, 1'b1, 1'b0);
        burst(1, 7, 1'b1, 8'd7, 1'b1, 1'b0);

        // Gap changes to 3: one mismatch, unlock, relock after 3 matches.
        tag = "gap3_mismatch";
        burst(1, 3, 1'b1, 8'd7, 1'b1, 1'b0);
        burst(1, 3, 1'b1, 8'd3, 1'b0, 1'b1);
        tag = "gap3_relock";
        burst(1, 3, 1'b1, 8'd3, 1'b0, 1'b0);
        burst(1, 3, 1'b1, 8'd3, 1'b0, 1'b0);
        burst(1, 3, 1'b1, 8'd3, 1'b1, 1'b0);

        // Silence while locked: timeout once on the sample after the counter reaches 255.
        tag = "timeout";
        tick(1'b1, 1'b1, 1'b1, 8'd3, 1'b1, 1'b0, 1'b0);
        quiet_n(1'b0, 255);
        tick(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        tag = "idle_no_timeout";
        quiet_n(1'b0, 6);
        tag = "idle_edge";
        tick(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

        // Saturation and edge in the same cycle: edge wins with gap 255.
        tag = "sat_edge";
        quiet_n(1'b0, 255);
        tick(1'b1, 1'b1, 1'b1, 8'd255, 1'b0, 1'b0, 1'b0);
        quiet(1'b0);

        // 111000 pattern: one pulse per high run, gap 3, lock after 3 matches.
        tag = "run3_reset";
        do_reset(1'b0);
        tag = "run3";
        burst(3, 3, 1'b0, 8'd0, 1'b0, 1'b0);
        burst(3, 3, 1'b1, 8'd3, 1'b0, 1'b0);
        burst(3, 3, 1'b1, 8'd3, 1'b0, 1'b0);
        burst(3, 3, 1'b1, 8'd3, 1'b0, 1'b0);
        burst(3, 3, 1'b1, 8'd3, 1'b1, 1'b0);
        burst(3, 3, 1'b1, 8'd3, 1'b1, 1'b0);

        // Reset while locked with the line high: reset beats the edge.
        tag = "reset_locked";
        do_reset(1'b1);
        tag = "post_reset_edge";
        tick(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        tag = "const_one";
        quiet_n(1'b1, 300);

        // Gap 2 becomes the reference, then the minimum gap of 1 mismatches.
        tag = "gap2";
        quiet_n(1'b0, 2);
        tick(1'b1, 1'b1, 1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
        quiet(1'b0);
        tag = "gap1_mismatch";
        tick(1'b1, 1'b1, 1'b1, 8'd1, 1'b0, 1'b1, 1'b0);
        tag = "sticky_hold";
        quiet_n(1'b1, 2);
        quiet_n(1'b0, 4);

        tag = "sticky_clear";
        do_reset(1'b0);
        quiet_n(1'b0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
